// File: rtl/prog_counter.sv
`default_nettype none
// ============================================================================
//  Module      : prog_counter
//  Description : Programmable timebase / event counter. Provides enable,
//                synchronous load, up/down counting by STEP, programmable
//                terminal value (period), clock prescaler, a registered
//                one-cycle terminal-count pulse and a continuous or one-shot
//                mode with a sticky done flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_counter #(
    parameter int WIDTH = 24,
    parameter int STEP  = 1,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    input  logic             oneshot,
    input  logic [WIDTH-1:0] period,
    input  logic [PRE_W-1:0] prescale,
    output logic [WIDTH-1:0] value,
    output logic             tc,
    output logic             done
);

    typedef enum logic [0:0] {
        ST_COUNT = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    // STEP in the counter width and in the one-bit-wider sum domain, so that
    // value+STEP can never silently wrap past the top of the range.
    localparam logic [WIDTH-1:0] C_STEP   = WIDTH'(STEP);
    localparam logic [WIDTH:0]   C_STEP_X = (WIDTH+1)'(STEP);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   value_q, value_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic               tc_q, tc_d;
    logic               done_q, done_d;

    logic               tick;
    logic [WIDTH:0]     sum;
    logic               terminal;

    // Prescaler: counts enabled cycles in COUNT and emits a tick every prescale+1.
    always_comb begin
        tick      = 1'b0;
        pre_cnt_d = pre_cnt_q;
        if (load) begin
            pre_cnt_d = '0;
        end else if (en && (state_q == ST_COUNT)) begin
            if (pre_cnt_q == prescale) begin
                pre_cnt_d = '0;
                tick      = 1'b1;
            end else begin
                pre_cnt_d = pre_cnt_q + PRE_W'(1);
            end
        end
    end

    // Terminal detection: up overflows past period, down would go below zero.
    always_comb begin
        sum      = {1'b0, value_q} + C_STEP_X;
        terminal = up ? (sum > {1'b0, period}) : (value_q < C_STEP);
    end

    // Next-state, value, pulse and done flag; load always beats a tick.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        tc_d    = 1'b0;
        done_d  = done_q;
        if (load) begin
            value_d = load_val;
            done_d  = 1'b0;
            state_d = ST_COUNT;
        end else if (tick) begin
            if (terminal) begin
                tc_d = 1'b1;
                if (oneshot) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    value_d = up ? '0 : period;
                end
            end else if (up) begin
                value_d = sum[WIDTH-1:0];
            end else begin
                value_d = value_q - C_STEP;
            end
        end
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_COUNT;
            value_q   <= '0;
            pre_cnt_q <= '0;
            tc_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            pre_cnt_q <= pre_cnt_d;
            tc_q      <= tc_d;
            done_q    <= done_d;
        end
    end

    assign value = value_q;
    assign tc    = tc_q;
    assign done  = done_q;

endmodule
`default_nettype wire

// File: doc/prog_counter.md
Name: prog_counter

Overview:
- Parametrised, programmable successor to the basic free-running counter.
- Adds enable, synchronous load, up/down direction, programmable modulo (period), clock prescaler, terminal-count pulse, and continuous or one-shot mode.
- Serves as the general timebase and event counter for timers, display refresh dividers and delay generators across the FPGA design.

Parameters:
- WIDTH, 24, counter and period bus width in bits.
- STEP, 1, increment/decrement amount applied per tick; must satisfy 1 <= STEP <= 2^WIDTH-1.
- PRE_W, 8, prescaler bus width in bits.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable; prescaler and value hold when low.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value written to the counter on load.
- up  input  1  direction: 1 = count up, 0 = count down.
- oneshot  input  1  mode: 0 = continuous wrap, 1 = stop at terminal count.
- period  input  WIDTH  terminal value; count range is 0..period.
- prescale  input  PRE_W  a tick occurs every prescale+1 enabled cycles.
- value  output  WIDTH  current count.
- tc  output  1  terminal-count pulse; one cycle wide, registered.
- done  output  1  one-shot finished flag; sticky.

Behaviour:
- Reset (async assert, sync deassert by the user):
  - value=0, prescaler=0, tc=0, done=0, state=COUNT.
- Priority per edge: reset > load > tick > hold.
- Load:
  - value<=load_val, prescaler<=0, done<=0, state<=COUNT, tc<=0.
  - Load works regardless of en and state.
- Prescaler:
  - When en=1, state=COUNT and no load: if pre_cnt==prescale then pre_cnt<=0 and tick=1; else pre_cnt<=pre_cnt+1.
  - prescale=0 gives a tick every enabled cycle.
  - en=0 freezes pre_cnt and value; tc is 0 on those cycles.
- Up tick:
  - Compute sum=value+STEP in WIDTH+1 bits.
  - If sum>period: terminal event. Otherwise value<=sum[WIDTH-1:0].
- Down tick:
  - If value<STEP: terminal event. Otherwise value<=value-STEP.
- Terminal event, continuous mode:
  - Up mode reloads value<=0; down mode reloads value<=period.
  - tc<=1 for that one cycle.
- Terminal event, one-shot mode:
  - value holds its current value; tc<=1 for one cycle; done<=1; state<=DONE.
- tc is registered and is high exactly on the cycle following the edge that performed the terminal update. It is 0 on all other cycles.
- State machine:
  - COUNT: ticks processed as above.
  - DONE: value, prescaler and tc frozen (tc=0); only load or reset leave this state, both returning to COUNT.
  - Changing oneshot while in DONE has no effect.
- Modulo: with STEP=1 the sequence period is period+1 ticks in either direction.
- Boundary cases:
  - period changed so that value>period: the next up tick is a terminal event. The next down tick decrements normally and never clamps to period.
  - period=0 with STEP=1: every tick is a terminal event and value stays 0.
  - The sum is computed at WIDTH+1 bits, so value+STEP never wraps silently past 2^WIDTH-1.
  - Direction change mid-count takes effect on the next tick; there is no pending-state carryover.
  - load and tick on the same edge: load wins, and that tick is discarded.
  - Reset asserted mid-count or in DONE clears everything immediately, independent of clk.

Test Plan:
- Reset, then en=1, up=1, period=9, prescale=0, oneshot=0 for 25 cycles:
  - value runs 0..9,0..9,0..4.
  - tc is high on the cycle value returns to 0 (two pulses).
  - done stays 0.
- up=0, period=5, load with load_val=5, then 7 enabled cycles:
  - value 5,4,3,2,1,0,5.
  - tc pulses once, on the cycle value reloads to 5.
- prescale=3, up=1, period=2, en=1 for 16 cycles:
  - value advances every 4th cycle as 0,0,0,0,1,1,1,1,2,2,2,2,0.
  - tc pulses exactly once.
- oneshot=1, up=1, period=3, run 10 cycles:
  - value 0,1,2,3, then holds 3.
  - tc pulses once; done=1 and stays 1.
  - A subsequent load with load_val=0 clears done and counting resumes.
- STEP=4 build (WIDTH=8), period=10, up=1:
  - value 0,4,8,0,4.
  - tc pulses when 8 wraps to 0.
- Mid-count checks:
  - Toggle en=0 for 3 cycles: value and prescaler hold.
  - Assert load together with a tick: load_val appears and there is no tc.
  - Assert reset asynchronously between clock edges: all outputs are 0 before the next edge.
